// File: rtl/elevator_pkg.sv
// Shared elevator-controller definitions: default sizing and the car direction
// encoding consumed by the motion FSM.
package elevator_pkg;

    localparam int FLOORS_DEFAULT   = 8;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, run-length debounce counter,
// stable level and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised level disagrees with the stable one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/call_register.sv
// Pending-request register: debounced cabin/hall buttons latched until serviced,
// with registered above/below/here summaries and a pending-request count.
module call_register
    import elevator_pkg::*;
#(
    parameter  int FLOORS          = FLOORS_DEFAULT,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    localparam int FLOOR_W         = $clog2(FLOORS),
    localparam int CNT_W           = $clog2(3*FLOORS+1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn_cab,
    input  logic [FLOORS-1:0]  btn_up,
    input  logic [FLOORS-1:0]  btn_down,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic               serve_valid,
    input  logic [FLOOR_W-1:0] serve_floor,
    input  logic               serve_up,
    input  logic               serve_down,
    output logic [FLOORS-1:0]  cab_req,
    output logic [FLOORS-1:0]  up_req,
    output logic [FLOORS-1:0]  down_req,
    output logic               any_above,
    output logic               any_below,
    output logic               any_here,
    output logic [CNT_W-1:0]   req_count
);

    localparam int CH = 3*FLOORS;

    function automatic logic [CNT_W-1:0] popcount(input logic [CH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < CH; k++) c = c + CNT_W'(v[k]);
        return c;
    endfunction

    // No top-floor up button and no ground-floor down button exist.
    logic [FLOORS-1:0] up_mask, down_mask;
    assign up_mask   = {1'b0, {(FLOORS-1){1'b1}}};
    assign down_mask = {{(FLOORS-1){1'b1}}, 1'b0};

    logic unused_tied_btn;
    assign unused_tied_btn = btn_up[FLOORS-1] ^ btn_down[0];

    logic [CH-1:0] raw, press;
    assign raw = {btn_down & down_mask, btn_up & up_mask, btn_cab};

    for (genvar g = 0; g < CH; g++) begin : g_chan
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (raw[g]),
            .press_o (press[g])
        );
    end

    logic [FLOORS-1:0] cab_q, cab_d, up_q, up_d, down_q, down_d;
    logic              above_q, above_d, below_q, below_d, here_q, here_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FLOORS-1:0] pend;

    // A service clear overrides a press landing on the same bit.
    always_comb begin
        cab_d  = cab_q ^ press[FLOORS-1:0];
        up_d   = up_q | press[2*FLOORS-1:FLOORS];
        down_d = down_q | press[3*FLOORS-1:2*FLOORS];
        if (serve_valid && (int'(serve_floor) < FLOORS)) begin
            cab_d[serve_floor] = 1'b0;
            if (serve_up)   up_d[serve_floor]   = 1'b0;
            if (serve_down) down_d[serve_floor] = 1'b0;
        end
        up_d   = up_d & up_mask;
        down_d = down_d & down_mask;
    end

    assign pend = cab_q | up_q | down_q;

    always_comb begin
        above_d = 1'b0;
        below_d = 1'b0;
        here_d  = 1'b0;
        count_d = popcount({down_q, up_q, cab_q});
        if (int'(current_floor) < FLOORS) begin
            for (int j = 0; j < FLOORS; j++) begin
                if (j > int'(current_floor)) above_d = above_d | pend[j];
                if (j < int'(current_floor)) below_d = below_d | pend[j];
            end
            here_d = pend[current_floor];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cab_q   <= '0;
            up_q    <= '0;
            down_q  <= '0;
            above_q <= 1'b0;
            below_q <= 1'b0;
            here_q  <= 1'b0;
            count_q <= '0;
        end else begin
            cab_q   <= cab_d;
            up_q    <= up_d;
            down_q  <= down_d;
            above_q <= above_d;
            below_q <= below_d;
            here_q  <= here_d;
            count_q <= count_d;
        end
    end

    assign cab_req   = cab_q;
    assign up_req    = up_q;
    assign down_req  = down_q;
    assign any_above = above_q;
    assign any_below = below_q;
    assign any_here  = here_q;
    assign req_count = count_q;

endmodule

// File: tb/tb_call_register.sv
// Bench for call_register: directed scenarios plus a long random run, all
// checked every cycle against a window-based behavioural model.
module tb_call_register;

    localparam int F  = 8;
    localparam int DB = 4;
    localparam int FW = 3;
    localparam int CW = 5;
    localparam int CH = 3*F;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [F-1:0]  btn_cab = '0, btn_up = '0, btn_down = '0;
    logic [FW-1:0] current_floor = '0;
    logic          serve_valid = 1'b0;
    logic [FW-1:0] serve_floor = '0;
    logic          serve_up = 1'b0, serve_down = 1'b0;
    logic [F-1:0]  cab_req, up_req, down_req;
    logic          any_above, any_below, any_here;
    logic [CW-1:0] req_count;

    call_register #(.FLOORS(F), .DEBOUNCE_CYCLES(DB)) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_cab       (btn_cab),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .current_floor (current_floor),
        .serve_valid   (serve_valid),
        .serve_floor   (serve_floor),
        .serve_up      (serve_up),
        .serve_down    (serve_down),
        .cab_req       (cab_req),
        .up_req        (up_req),
        .down_req      (down_req),
        .any_above     (any_above),
        .any_below     (any_below),
        .any_here      (any_here),
        .req_count     (req_count)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: request vectors, summaries, and per channel the recent raw
    // samples (bit j = sample taken j edges ago), stable level and pending press.
    logic [F-1:0]  cab_m, up_m, down_m;
    logic          above_m, below_m, here_m;
    int            count_m;
    logic [15:0]   hist [CH];
    logic [CH-1:0] stab_m, pend_m;

    task automatic model_reset();
        cab_m = '0; up_m = '0; down_m = '0;
        above_m = 1'b0; below_m = 1'b0; here_m = 1'b0; count_m = 0;
        stab_m = '0; pend_m = '0;
        for (int c = 0; c < CH; c++) hist[c] = '0;
    endtask

    task automatic model_step();
        logic [F-1:0]  p, cab_n, up_n, down_n;
        logic [CH-1:0] rawv;
        logic [DB-1:0] win;
        if (!reset) begin
            model_reset();
            return;
        end
        p = cab_m | up_m | down_m;
        above_m = 1'b0; below_m = 1'b0; here_m = 1'b0;
        if (int'(current_floor) < F) begin
            for (int j = 0; j < F; j++) begin
                if (j > int'(current_floor) && p[j]) above_m = 1'b1;
                if (j < int'(current_floor) && p[j]) below_m = 1'b1;
            end
            here_m = p[current_floor];
        end
        count_m = $countones(cab_m) + $countones(up_m) + $countones(down_m);
        cab_n  = cab_m ^ pend_m[F-1:0];
        up_n   = up_m | pend_m[2*F-1:F];
        down_n = down_m | pend_m[3*F-1:2*F];
        if (serve_valid && int'(serve_floor) < F) begin
            cab_n[serve_floor] = 1'b0;
            if (serve_up)   up_n[serve_floor]   = 1'b0;
            if (serve_down) down_n[serve_floor] = 1'b0;
        end
        up_n[F-1]  = 1'b0;
        down_n[0]  = 1'b0;
        cab_m = cab_n; up_m = up_n; down_m = down_n;
        // A level is accepted once the last DB synchronised samples agree on it.
        rawv = {btn_down, btn_up, btn_cab};
        rawv[2*F-1] = 1'b0;
        rawv[2*F]   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            hist[c]   = {hist[c][14:0], rawv[c]};
            win       = hist[c][DB+1:2];
            pend_m[c] = 1'b0;
            if (!stab_m[c] && (&win)) begin
                stab_m[c] = 1'b1;
                pend_m[c] = 1'b1;
            end else if (stab_m[c] && !(|win)) begin
                stab_m[c] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("cab_req",   32'(cab_req),   32'(cab_m));
        check_val("up_req",    32'(up_req),    32'(up_m));
        check_val("down_req",  32'(down_req),  32'(down_m));
        check_val("any_above", 32'(any_above), 32'(above_m));
        check_val("any_below", 32'(any_below), 32'(below_m));
        check_val("any_here",  32'(any_here),  32'(here_m));
        check_val("req_count", 32'(req_count), 32'(count_m));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_cab"},   32'(cab_req),   32'd0);
        check_val({tag, "_up"},    32'(up_req),    32'd0);
        check_val({tag, "_down"},  32'(down_req),  32'd0);
        check_val({tag, "_sum"},   32'({any_above, any_below, any_here}), 32'd0);
        check_val({tag, "_count"}, 32'(req_count), 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Called at a falling edge; asserts reset asynchronously in mid low phase.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        btn_cab = '0; btn_up = '0; btn_down = '0; serve_valid = 1'b0;
        #1;
        model_reset();
        check_zero(tag);
        run(2);
    endtask

    initial begin
        model_reset();
        #1;
        check_zero("por");
        run(3);

        reset = 1'b1;
        btn_cab = 8'h55;
        run(8);
        btn_cab = '0;
        run(8);
        check_val("cab_55", 32'(cab_req), 32'h55);

        do_reset("midrun_rst");
        reset = 1'b1;
        btn_cab[3] = 1'b1;
        run(6);
        check_val("cab3_edge5", 32'(cab_req), 32'h00);
        run(1);
        check_val("cab3_edge6", 32'(cab_req), 32'h08);
        btn_cab = '0;
        run(8);

        btn_up[2] = 1'b1; run(3); btn_up[2] = 1'b0; run(10);
        check_val("up2_glitch", 32'(up_req), 32'h00);
        btn_up[2] = 1'b1; run(10); btn_up[2] = 1'b0; run(10);
        check_val("up2_held", 32'(up_req[2]), 32'd1);
        btn_up[2] = 1'b1; run(10); btn_up[2] = 1'b0; run(10);
        check_val("up2_repress", 32'(up_req[2]), 32'd1);

        btn_cab[5] = 1'b1; run(8); btn_cab[5] = 1'b0; run(8);
        check_val("cab5_set", 32'(cab_req[5]), 32'd1);
        btn_cab[5] = 1'b1; run(8); btn_cab[5] = 1'b0; run(8);
        check_val("cab5_cancel", 32'(cab_req[5]), 32'd0);

        do_reset("sum_rst");
        reset = 1'b1;
        current_floor = 3'd3;
        btn_cab[6] = 1'b1; btn_down[1] = 1'b1;
        run(8);
        btn_cab = '0; btn_down = '0;
        run(8);
        check_val("sum_above", 32'(any_above), 32'd1);
        check_val("sum_below", 32'(any_below), 32'd1);
        check_val("sum_here",  32'(any_here),  32'd0);
        check_val("sum_count", 32'(req_count), 32'd2);

        btn_cab[4] = 1'b1; btn_up[4] = 1'b1; btn_down[4] = 1'b1;
        run(8);
        btn_cab = '0; btn_up = '0; btn_down = '0;
        run(8);
        serve_valid = 1'b1; serve_floor = 3'd4; serve_up = 1'b1; serve_down = 1'b0;
        run(1);
        serve_valid = 1'b0; serve_up = 1'b0;
        check_val("serve4_up",   32'(up_req[4]),   32'd0);
        check_val("serve4_cab",  32'(cab_req[4]),  32'd0);
        check_val("serve4_down", 32'(down_req[4]), 32'd1);

        btn_down[6] = 1'b1; btn_up[7] = 1'b1; btn_down[0] = 1'b1;
        run(6);
        serve_valid = 1'b1; serve_floor = 3'd6; serve_down = 1'b1;
        run(1);
        serve_valid = 1'b0; serve_down = 1'b0;
        check_val("race_down6", 32'(down_req[6]), 32'd0);
        run(10);
        check_val("race_down6_hold", 32'(down_req[6]), 32'd0);
        check_val("tied_up7",   32'(up_req[7]),   32'd0);
        check_val("tied_down0", 32'(down_req[0]), 32'd0);
        btn_down = '0; btn_up = '0;
        run(8);

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < F; b++) begin
                if ($urandom_range(15) == 0) btn_cab[b]  = ~btn_cab[b];
                if ($urandom_range(15) == 0) btn_up[b]   = ~btn_up[b];
                if ($urandom_range(15) == 0) btn_down[b] = ~btn_down[b];
            end
            serve_valid = ($urandom_range(7) == 0);
            serve_floor = FW'($urandom_range(F-1));
            serve_up    = 1'($urandom_range(1));
            serve_down  = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) current_floor = FW'($urandom_range(F-1));
            if (c == 1500) begin
                do_reset("rand_rst");
                reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
